// File: rtl/uart_frame_loader_if.sv
// Pixel write port and frame status of the UART frame loader.
interface uart_frame_loader_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  frame_done;
  logic                  frame_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output busy, frame_done, frame_err
  );
  modport slave (
    input wr_en, wr_addr, wr_data,
    input busy, frame_done, frame_err
  );
endinterface

// File: rtl/uart_frame_loader.sv
// 8N1 UART receiver feeding a frame loader that writes pixels
// into a frame buffer, with optional sync header and timeout.
module uart_frame_loader #(
  parameter int         CLK_FREQ     = 12000000,
  parameter int         BAUD         = 115200,
  parameter int         H_PIXELS     = 100,
  parameter int         V_PIXELS     = 100,
  parameter int         ADDR_WIDTH   = 14,
  parameter int         DATA_WIDTH   = 8,
  parameter int         HEADER_EN    = 1,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic clk_in,
  input  logic reset,
  input  logic rx,
  uart_frame_loader_if.master wr
);
  localparam int BIT_TICKS  = CLK_FREQ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int PIXELS     = H_PIXELS * V_PIXELS;
  localparam int TO_TICKS   = TIMEOUT_BITS * BIT_TICKS;
  localparam int TW         = $clog2(BIT_TICKS + 1);
  localparam int OW         = $clog2(TO_TICKS + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_TICKS - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TO_TICKS - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(PIXELS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_RECV = 2'd1;
  localparam logic [1:0] L_DONE = 2'd2;

  logic rx_meta, rx_sync, rx_prev;

  logic [1:0]    rx_state;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_vld;
  logic          byte_err;

  logic [1:0]            ld_state;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [OW-1:0]         timer;
  logic                  do_write;
  logic                  last_pix;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      byte_err <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      byte_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (tick == HALF_LAST) begin
            tick     <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        RX_DATA: begin
          if (tick == BIT_LAST) begin
            tick    <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        RX_STOP: begin
          if (tick == BIT_LAST) begin
            tick     <= '0;
            rx_state <= RX_IDLE;
            byte_vld <= rx_sync;
            byte_err <= !rx_sync;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Raw streams write the very first byte straight from idle.
  assign do_write = byte_vld &&
    (ld_state == L_RECV || (ld_state == L_IDLE && HEADER_EN == 0));
  assign last_pix = (pix_cnt == PIX_LAST);
  assign wr.busy  = (ld_state != L_IDLE);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ld_state      <= L_IDLE;
      pix_cnt       <= '0;
      timer         <= '0;
      wr.wr_en      <= 1'b0;
      wr.wr_addr    <= '0;
      wr.wr_data    <= '0;
      wr.frame_done <= 1'b0;
      wr.frame_err  <= 1'b0;
    end else begin
      wr.wr_en      <= do_write;
      wr.frame_done <= 1'b0;
      wr.frame_err  <= byte_err;
      if (do_write) begin
        wr.wr_addr <= pix_cnt;
        wr.wr_data <= shreg[DATA_WIDTH-1:0];
      end
      case (ld_state)
        L_IDLE: begin
          timer <= '0;
          if (do_write) begin
            ld_state <= last_pix ? L_DONE : L_RECV;
            pix_cnt  <= last_pix ? '0 : pix_cnt + ADDR_WIDTH'(1);
          end else if (byte_vld && shreg == SYNC_BYTE) begin
            ld_state <= L_RECV;
            pix_cnt  <= '0;
          end
        end
        L_RECV: begin
          if (byte_err) begin
            ld_state <= L_IDLE;
            pix_cnt  <= '0;
            timer    <= '0;
          end else if (do_write) begin
            timer    <= '0;
            ld_state <= last_pix ? L_DONE : L_RECV;
            pix_cnt  <= last_pix ? '0 : pix_cnt + ADDR_WIDTH'(1);
          end else if (timer == TO_LAST) begin
            wr.frame_err <= 1'b1;
            ld_state     <= L_IDLE;
            pix_cnt      <= '0;
            timer        <= '0;
          end else begin
            timer <= timer + OW'(1);
          end
        end
        L_DONE: begin
          wr.frame_done <= 1'b1;
          ld_state      <= L_IDLE;
          pix_cnt       <= '0;
          timer         <= '0;
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: header and raw instances on a
// 2x2 frame, table vectors, corner sequences, random streams.
module tb_uart_frame_loader;
  localparam int BT  = 104;
  localparam int PIX = 4;
  localparam int TO  = 32 * BT;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    string      name;
    bit         raw;
    int         nb;
    logic [7:0] bytes [6];
    bit         stop_last;
    int         nw;
    logic [7:0] wdata [4];
    int         ndone;
    int         nerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  uart_frame_loader_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) ia ();
  uart_frame_loader_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) ib ();

  uart_frame_loader #(
    .CLK_FREQ(12000000), .BAUD(115200),
    .H_PIXELS(2), .V_PIXELS(2),
    .ADDR_WIDTH(14), .DATA_WIDTH(8),
    .HEADER_EN(1), .SYNC_BYTE(8'hA5),
    .TIMEOUT_BITS(32)
  ) dut_a (
    .clk_in(clk), .reset(rst_n), .rx(rx_a), .wr(ia)
  );

  uart_frame_loader #(
    .CLK_FREQ(12000000), .BAUD(115200),
    .H_PIXELS(2), .V_PIXELS(2),
    .ADDR_WIDTH(14), .DATA_WIDTH(8),
    .HEADER_EN(0), .SYNC_BYTE(8'hA5),
    .TIMEOUT_BITS(32)
  ) dut_b (
    .clk_in(clk), .reset(rst_n), .rx(rx_b), .wr(ib)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wr_t qa[$];
  wr_t qb[$];
  int  done_a = 0, err_a = 0, adj_a = 0, oob_a = 0;
  int  done_b = 0, err_b = 0, adj_b = 0, oob_b = 0;
  int  wr_cyc_a = 0, err_cyc_a = 0;
  bit  lastp_a = 0, lastp_b = 0;

  always @(negedge clk) begin
    if (ia.wr_en) begin
      qa.push_back({ia.wr_addr, ia.wr_data});
      wr_cyc_a = cyc;
      if (ia.wr_addr >= 14'(PIX)) oob_a++;
    end
    if (ia.frame_done) begin
      done_a++;
      if (!lastp_a) adj_a++;
    end
    if (ia.frame_err) begin
      err_a++;
      err_cyc_a = cyc;
    end
    lastp_a = ia.wr_en && ia.wr_addr == 14'(PIX - 1);
  end

  always @(negedge clk) begin
    if (ib.wr_en) begin
      qb.push_back({ib.wr_addr, ib.wr_data});
      if (ib.wr_addr >= 14'(PIX)) oob_b++;
    end
    if (ib.frame_done) begin
      done_b++;
      if (!lastp_b) adj_b++;
    end
    if (ib.frame_err) err_b++;
    lastp_b = ib.wr_en && ib.wr_addr == 14'(PIX - 1);
  end

  int mk_q[2], mk_d[2], mk_e[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic mark();
    mk_q[0] = qa.size(); mk_d[0] = done_a; mk_e[0] = err_a;
    mk_q[1] = qb.size(); mk_d[1] = done_b; mk_e[1] = err_b;
  endtask

  task automatic check_dut(input int d, input string nm,
                           input wr_t exp[$], input int xd,
                           input int xe, input int xb);
    int  n;
    wr_t w;
    n = (d == 0 ? qa.size() : qb.size()) - mk_q[d];
    chk({nm, ".nwr"}, n, exp.size());
    for (int i = 0; i < exp.size() && i < n; i++) begin
      w = (d == 0) ? qa[mk_q[d] + i] : qb[mk_q[d] + i];
      chk($sformatf("%s.wr%0d", nm, i), 32'(w), 32'(exp[i]));
    end
    chk({nm, ".done"}, (d == 0 ? done_a : done_b) - mk_d[d], xd);
    chk({nm, ".err"}, (d == 0 ? err_a : err_b) - mk_e[d], xe);
    chk({nm, ".busy"}, d == 0 ? ia.busy : ib.busy, xb);
    chk({nm, ".adj"}, d == 0 ? adj_a : adj_b, 0);
    chk({nm, ".oob"}, d == 0 ? oob_a : oob_b, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".a"}, {ia.wr_en, ia.wr_addr, ia.wr_data,
                     ia.busy, ia.frame_done, ia.frame_err}, 0);
    chk({nm, ".b"}, {ib.wr_en, ib.wr_addr, ib.wr_data,
                     ib.busy, ib.frame_done, ib.frame_err}, 0);
  endtask

  task automatic idle(input int bits);
    repeat (bits * BT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop,
                           input bit en_a, input bit en_b);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (en_a) rx_a = fr[i];
      if (en_b) rx_b = fr[i];
      repeat (BT) @(negedge clk);
    end
    if (en_a) rx_a = 1'b1;
    if (en_b) rx_b = 1'b1;
    repeat (BT) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Frame rules applied to a whole byte list at once.
  task automatic model(input logic [7:0] s[$], input bit raw,
                       output wr_t w[$], output int nd, output int bz);
    int idx;
    bit on;
    w = {}; nd = 0; idx = 0; on = 0;
    foreach (s[i]) begin
      if (on || raw) begin
        w.push_back({14'(idx), s[i]});
        idx++;
        on = 1;
      end else if (s[i] == 8'hA5) begin
        on = 1;
        idx = 0;
      end
      if (idx == PIX) begin
        nd++;
        on = 0;
        idx = 0;
      end
    end
    bz = on;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[5];
    wr_t        exp[$];
    logic [7:0] stream[$];
    logic [7:0] b;
    int         nd, bz, dly, len;

    vt[0] = '{"sync_frame", 0, 5,
              '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 1, 4,
              '{8'h11, 8'h22, 8'h33, 8'h44}, 1, 0};
    vt[1] = '{"junk_sync", 0, 6,
              '{8'h11, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03}, 1, 4,
              '{8'hA5, 8'h01, 8'h02, 8'h03}, 1, 0};
    vt[2] = '{"raw_frame", 1, 4,
              '{8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00}, 1, 4,
              '{8'h05, 8'h06, 8'h07, 8'h08}, 1, 0};
    vt[3] = '{"stop_err", 0, 2,
              '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0,
              '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1};
    vt[4] = '{"raw_abort", 1, 2,
              '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1,
              '{8'h01, 8'h00, 8'h00, 8'h00}, 0, 1};

    rx_a = 1'b1;
    rx_b = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    for (int v = 0; v < 5; v++) begin
      mark();
      for (int i = 0; i < vt[v].nb; i++)
        send_byte(vt[v].bytes[i],
                  (i == vt[v].nb - 1) ? vt[v].stop_last : 1'b1,
                  !vt[v].raw, vt[v].raw);
      idle(2);
      exp = {};
      for (int i = 0; i < vt[v].nw; i++)
        exp.push_back({14'(i), vt[v].wdata[i]});
      check_dut(vt[v].raw ? 1 : 0, vt[v].name, exp,
                vt[v].ndone, vt[v].nerr, 0);
      if (v == 0)
        chk("hold", {ia.wr_en, ia.wr_addr, ia.wr_data},
            {1'b0, 14'd3, 8'h44});
    end

    mark();
    send_byte(8'hA5, 1, 1, 0);
    send_byte(8'h11, 1, 1, 0);
    idle(40);
    exp = {};
    exp.push_back({14'd0, 8'h11});
    check_dut(0, "timeout", exp, 0, 1, 0);
    dly = err_cyc_a - wr_cyc_a;
    checks++;
    if (dly < TO - 1 || dly > TO + 1) begin
      failures++;
      $display("FAIL timeout.dly got=%0d exp=%0d", dly, TO);
    end

    mark();
    send_byte(8'hA5, 1, 1, 0);
    send_byte(8'h77, 1, 1, 0);
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    idle(2);
    send_byte(8'h78, 1, 1, 0);
    send_byte(8'h79, 1, 1, 0);
    send_byte(8'h7A, 1, 1, 0);
    idle(2);
    exp = {};
    exp.push_back({14'd0, 8'h77});
    exp.push_back({14'd1, 8'h78});
    exp.push_back({14'd2, 8'h79});
    exp.push_back({14'd3, 8'h7A});
    check_dut(0, "glitch", exp, 1, 0, 0);

    reset_dut();
    mark();
    send_byte(8'hA5, 1, 1, 1);
    send_byte(8'h06, 1, 1, 1);
    fork
      send_byte(8'h07, 1, 1, 1);
      begin
        idle(4);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("mid_reset");
      end
    join
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h09, 1, 1, 1);
    send_byte(8'h0A, 1, 1, 1);
    send_byte(8'h0B, 1, 1, 1);
    send_byte(8'h0C, 1, 1, 1);
    idle(2);
    exp = {};
    exp.push_back({14'd0, 8'h06});
    check_dut(0, "rst_hdr", exp, 0, 0, 0);
    exp = {};
    exp.push_back({14'd0, 8'hA5});
    exp.push_back({14'd1, 8'h06});
    exp.push_back({14'd0, 8'h09});
    exp.push_back({14'd1, 8'h0A});
    exp.push_back({14'd2, 8'h0B});
    exp.push_back({14'd3, 8'h0C});
    check_dut(1, "rst_raw", exp, 1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      reset_dut();
      mark();
      stream = {};
      len = $urandom_range(5, 9);
      for (int i = 0; i < len; i++) begin
        b = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
        stream.push_back(b);
        send_byte(b, 1, 1, 1);
        idle($urandom_range(0, 2));
      end
      idle(2);
      model(stream, 0, exp, nd, bz);
      check_dut(0, $sformatf("rnd%0d_hdr", r), exp, nd, 0, bz);
      model(stream, 1, exp, nd, bz);
      check_dut(1, $sformatf("rnd%0d_raw", r), exp, nd, 0, bz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
